demux16b_1x2: RTL and testbench

DEMUX16B_1X2 -- requirements
Module: demux16b_1x2

---
 rtl/demux16b_1x2_pkg.sv | 18 +
 rtl/demux16b_1x2_if.sv | 35 +++
 rtl/demux16b_1x2_fifo2.sv | 54 +++++
 rtl/demux16b_1x2.sv | 65 ++++++
 tb/tb_demux16b_1x2.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demux16b_1x2_pkg.sv
// Shared constants and types for the 1-to-2 word demultiplexer and its channel FIFOs.
package demux16b_1x2_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int NUM_CH     = 2;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_e;

endpackage

// File: rtl/demux16b_1x2_if.sv
// Source-side and sink-side handshake bundle of the demultiplexer.
interface demux16b_1x2_if
    import demux16b_1x2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic              in_addr;
    logic [DATA_W-1:0] in_data;

    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic [CNT_W-1:0]  out0_cnt;

    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic [CNT_W-1:0]  out1_cnt;

    modport master (
        output in_valid, in_addr, in_data, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_cnt,
               out1_valid, out1_data, out1_cnt
    );

    modport slave (
        input  in_valid, in_addr, in_data, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_cnt,
               out1_valid, out1_data, out1_cnt
    );

endinterface

// File: rtl/demux16b_1x2_fifo2.sv
// Small register FIFO used as the per-channel buffer; storage is cleared on reset so
// dout reads zero afterwards.
module fifo2
    import demux16b_1x2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [OCC_W-1:0]  occ_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (occ_reg == OCC_W'(FIFO_DEPTH));
    assign empty   = (occ_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ_reg <= occ_reg + OCC_W'(1);
                2'b01:   occ_reg <= occ_reg - OCC_W'(1);
                default: occ_reg <= occ_reg;
            endcase
        end
    end

endmodule

// File: rtl/demux16b_1x2.sv
// Routes each accepted word to one of two buffered channels and counts the words
// delivered on each channel.
module demux16b_1x2
    import demux16b_1x2_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    demux16b_1x2_if.slave  bus
);
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] out_ready;
    logic              in_ready;
    chan_e             sel;

    assign sel       = chan_e'(bus.in_addr);
    assign out_ready = {bus.out1_ready, bus.out0_ready};

    // Readiness depends only on registered occupancy, so a full channel stays closed
    // even in a cycle where it is popping.
    assign in_ready     = (sel == CH1) ? !full[1] : !full[0];
    assign bus.in_ready = in_ready;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : ch_g
            logic [DATA_W-1:0] dout;
            logic [CNT_W-1:0]  cnt_reg;

            assign push[gi] = bus.in_valid && in_ready && (sel == chan_e'(gi));
            assign pop[gi]  = !empty[gi] && out_ready[gi];

            fifo2 #(.DATA_W(DATA_W)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[gi]),
                .pop   (pop[gi]),
                .din   (bus.in_data),
                .dout  (dout),
                .full  (full[gi]),
                .empty (empty[gi])
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (pop[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign bus.out0_valid = !empty[0];
    assign bus.out0_data  = ch_g[0].dout;
    assign bus.out0_cnt   = ch_g[0].cnt_reg;
    assign bus.out1_valid = !empty[1];
    assign bus.out1_data  = ch_g[1].dout;
    assign bus.out1_cnt   = ch_g[1].cnt_reg;

endmodule

// File: tb/tb_demux16b_1x2.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_demux16b_1x2;
    localparam int DW = 16;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux16b_1x2_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    demux16b_1x2 #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: one queue per channel plus delivered-word totals.
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            del0 = 0;
    int            del1 = 0;
    bit            last_in_hs;

    task automatic model_clear();
        q0.delete();
        q1.delete();
        del0 = 0;
        del1 = 0;
    endtask

    // Advance one clock edge and apply the handshakes the model predicts.
    task automatic tick();
        bit            hs_in;
        bit            hs0;
        bit            hs1;
        bit            a;
        logic [DW-1:0] d;
        a     = bus.in_addr;
        d     = bus.in_data;
        hs_in = bus.in_valid && ((a ? q1.size() : q0.size()) < 2);
        hs0   = bus.out0_ready && (q0.size() > 0);
        hs1   = bus.out1_ready && (q1.size() > 0);
        @(posedge clk);
        #1;
        if (hs0) begin void'(q0.pop_front()); del0++; end
        if (hs1) begin void'(q1.pop_front()); del1++; end
        if (hs_in) begin
            if (a) q1.push_back(d);
            else   q0.push_back(d);
        end
        last_in_hs = hs_in;
    endtask

    task automatic drive(input bit v, input bit a, input logic [DW-1:0] d);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    task automatic test_reset_initial();
        rst = 1'b1;
        drive(1'b0, 1'b0, '0);
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out0_valid, bus.out1_valid, bus.out0_data, bus.out1_data, bus.out0_cnt, bus.out1_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b%b d0=%h d1=%h c0=%h c1=%h exp all zero",
                     bus.out0_valid, bus.out1_valid, bus.out0_data, bus.out1_data, bus.out0_cnt, bus.out1_cnt);
        end
        rst = 1'b0;
        model_clear();
        for (int a = 0; a < 2; a++) begin
            bus.in_addr = a[0];
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_in_ready addr=%0d got=%b exp=1", a, bus.in_ready);
            end
        end
        $display("test_reset_initial done");
    endtask

    task automatic test_routing();
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1234);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL routing_pre_accept got rdy=%b v0=%b exp rdy=1 v0=0", bus.in_ready, bus.out0_valid);
        end
        tick();
        drive(1'b1, 1'b1, 16'hBEEF);
        #1;
        checks++;
        if (bus.out0_valid !== 1'b1 || bus.out0_data !== 16'h1234 || bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL routing_ch0 got v0=%b d0=%h v1=%b exp v0=1 d0=1234 v1=0",
                     bus.out0_valid, bus.out0_data, bus.out1_valid);
        end
        tick();
        drive(1'b0, 1'b0, 16'hFFFF);
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 16'hBEEF || bus.out0_valid !== 1'b0) begin
            errors++;
            $display("FAIL routing_ch1 got v1=%b d1=%h v0=%b exp v1=1 d1=beef v0=0",
                     bus.out1_valid, bus.out1_data, bus.out0_valid);
        end
        tick();
        checks++;
        if (bus.out0_cnt !== 8'd1 || bus.out1_cnt !== 8'd1 || bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL routing_cnt got c0=%0d c1=%0d v1=%b exp c0=1 c1=1 v1=0",
                     bus.out0_cnt, bus.out1_cnt, bus.out1_valid);
        end
        $display("test_routing done");
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got[$];
        logic [DW-1:0] expw[3];
        expw[0] = 16'hA001;
        expw[1] = 16'hA002;
        expw[2] = 16'hA003;
        bus.out0_ready = 1'b0;
        drive(1'b1, 1'b0, 16'hA001);
        tick();
        drive(1'b1, 1'b0, 16'hA002);
        tick();
        drive(1'b1, 1'b0, 16'hA003);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready_full got=%b exp=0", bus.in_ready);
        end
        repeat (3) tick();
        checks++;
        if (bus.out0_data !== 16'hA001 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_stall_head got d0=%h rdy=%b exp d0=a001 rdy=0", bus.out0_data, bus.in_ready);
        end
        bus.out0_ready = 1'b1;
        for (int i = 0; i < 10 && got.size() < 3; i++) begin
            if (bus.out0_valid) got.push_back(bus.out0_data);
            tick();
            if (last_in_hs) bus.in_valid = 1'b0;
        end
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_drain_count got=%0d exp=3", got.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got[i] !== expw[i]) begin
                    errors++;
                    $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], expw[i]);
                end
            end
        end
        bus.in_valid = 1'b0;
        repeat (2) tick();
        $display("test_backpressure done");
    endtask

    task automatic test_independence();
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b1;
        drive(1'b1, 1'b0, 16'hC001);
        tick();
        drive(1'b1, 1'b0, 16'hC002);
        tick();
        drive(1'b1, 1'b1, 16'h5555);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL indep_in_ready got=%b exp=1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 16'h5555 || bus.out0_data !== 16'hC001) begin
            errors++;
            $display("FAIL indep_deliver got v1=%b d1=%h d0=%h exp v1=1 d1=5555 d0=c001",
                     bus.out1_valid, bus.out1_data, bus.out0_data);
        end
        tick();
        bus.in_addr = 1'b0;
        #1;
        checks++;
        if (bus.out1_valid !== 1'b0 || bus.out0_valid !== 1'b1 || bus.out0_data !== 16'hC001 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL indep_ch0_kept got v1=%b v0=%b d0=%h rdy0=%b exp v1=0 v0=1 d0=c001 rdy0=0",
                     bus.out1_valid, bus.out0_valid, bus.out0_data, bus.in_ready);
        end
        bus.out0_ready = 1'b1;
        repeat (3) tick();
        $display("test_independence done");
    endtask

    task automatic test_push_pop();
        bus.out1_ready = 1'b0;
        drive(1'b1, 1'b1, 16'hD001);
        tick();
        drive(1'b1, 1'b1, 16'hD002);
        bus.out1_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out1_data !== 16'hD001) begin
            errors++;
            $display("FAIL pp_before got rdy=%b d1=%h exp rdy=1 d1=d001", bus.in_ready, bus.out1_data);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out1_valid !== 1'b1 || bus.out1_data !== 16'hD002) begin
            errors++;
            $display("FAIL pp_head got v1=%b d1=%h exp v1=1 d1=d002", bus.out1_valid, bus.out1_data);
        end
        tick();
        checks++;
        if (bus.out1_valid !== 1'b0) begin
            errors++;
            $display("FAIL pp_occupancy got v1=%b exp=0", bus.out1_valid);
        end
        $display("test_push_pop done");
    endtask

    task automatic test_reset_midstream();
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i[1], DW'($urandom));
            tick();
        end
        drive(1'b1, 1'b0, 16'h7777);
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out0_valid, bus.out1_valid, bus.out0_data, bus.out1_data, bus.out0_cnt, bus.out1_cnt} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b%b d0=%h d1=%h c0=%h c1=%h exp all zero",
                     bus.out0_valid, bus.out1_valid, bus.out0_data, bus.out1_data, bus.out0_cnt, bus.out1_cnt);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int a = 0; a < 2; a++) begin
            bus.in_addr = a[0];
            #1;
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_release addr=%0d got rdy=%b v0=%b v1=%b exp rdy=1 v0=0 v1=0",
                         a, bus.in_ready, bus.out0_valid, bus.out1_valid);
            end
        end
        $display("test_reset_midstream done");
    endtask

    task automatic test_counter_wrap();
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        for (int i = 0; i < 600 && del0 < 257; i++) begin
            drive(del0 + q0.size() < 257, 1'b0, DW'($urandom));
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (del0 != 257 || bus.out0_cnt !== 8'd1 || bus.out1_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap got c0=%0d c1=%0d delivered=%0d exp c0=1 c1=0 delivered=257",
                     bus.out0_cnt, bus.out1_cnt, del0);
        end
        $display("test_counter_wrap done");
    endtask

    task automatic test_random();
        bit            exp_rdy;
        logic [DW-1:0] exp_d0;
        logic [DW-1:0] exp_d1;
        logic [DW-1:0] act_d0;
        logic [DW-1:0] act_d1;
        int            start_errors;
        start_errors = errors;
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, DW'($urandom));
            bus.out0_ready = $urandom_range(0, 2) != 0;
            bus.out1_ready = $urandom_range(0, 2) == 0;
            #1;
            exp_rdy = (bus.in_addr ? q1.size() : q0.size()) < 2;
            exp_d0  = (q0.size() > 0) ? q0[0] : '0;
            exp_d1  = (q1.size() > 0) ? q1[0] : '0;
            act_d0  = (q0.size() > 0) ? bus.out0_data : '0;
            act_d1  = (q1.size() > 0) ? bus.out1_data : '0;
            checks++;
            if ({bus.in_ready, bus.out0_valid, bus.out1_valid, act_d0, act_d1, bus.out0_cnt, bus.out1_cnt} !==
                {exp_rdy, q0.size() > 0, q1.size() > 0, exp_d0, exp_d1, CW'(del0), CW'(del1)}) begin
                errors++;
                $display("FAIL random cyc=%0d got rdy=%b v=%b%b d0=%h d1=%h c0=%0d c1=%0d exp rdy=%b v=%b%b d0=%h d1=%h c0=%0d c1=%0d",
                         i, bus.in_ready, bus.out0_valid, bus.out1_valid, act_d0, act_d1, bus.out0_cnt, bus.out1_cnt,
                         exp_rdy, q0.size() > 0, q1.size() > 0, exp_d0, exp_d1, CW'(del0), CW'(del1));
            end
            tick();
        end
        $display("test_random done errors_in_test=%0d", errors - start_errors);
    endtask

    initial begin
        test_reset_initial();
        test_routing();
        test_backpressure();
        test_independence();
        test_push_pop();
        test_reset_midstream();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
